piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_serializer_if.sv | 35 +++
 rtl/piso_bit_counter.sv | 45 ++++
 rtl/piso_serializer.sv | 94 +++++++++
 tb/tb_piso_serializer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer slice.
package piso_pkg;

    // Default parallel word width used by the serializer, its counter and its interface.
    localparam int PISO_DEFAULT_WIDTH = 4;

    // Serializer control states: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle between an upstream word source and the serializer.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;
    logic             o_d;
    logic             o_busy;
    logic             o_last;

    // Upstream side: offers words and observes the serial stream.
    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_d,
        input  o_busy,
        input  o_last
    );

    // Serializer side: takes words and produces the serial stream.
    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_d,
        output o_busy,
        output o_last
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer: 0 on the first bit, terminal on the last.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Reload on a new word, otherwise advance while shifting and wrap after the last bit.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register, cleared immediately by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_terminal = (count_q == LAST_COUNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: MSB first, one bit per cycle, back-to-back capable.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = PISO_DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    piso_serializer_if.slave  bus
);

    piso_state_t      state_q;
    piso_state_t      state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    logic busy;
    logic last;
    logic ready;
    logic accept;
    logic terminal;

    // The counter's terminal flag is only meaningful while a word is shifting.
    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (accept),
        .i_enable   (busy),
        .o_terminal (terminal)
    );

    assign busy   = (state_q == SHIFT);
    assign last   = busy && terminal;
    assign ready  = !i_rst && (!busy || last);
    assign accept = bus.i_valid && ready;

    // State register, forced to IDLE immediately by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a word starts or continues shifting; the stream ends after a last bit with no new word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register next value: capture on acceptance, otherwise move the next bit into the MSB.
    always_comb begin
        shreg_d = shreg_q;
        if (accept) begin
            shreg_d = bus.i_data;
        end else if (busy) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register, cleared immediately by reset so an aborted word leaves nothing behind.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Outputs decoded from registered state only; ready also drops while reset is held.
    always_comb begin
        bus.o_busy  = busy;
        bus.o_last  = last;
        bus.o_ready = ready;
        bus.o_d     = busy ? shreg_q[WIDTH-1] : IDLE_LEVEL;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_piso_serializer;

    localparam int W = 4;

    logic clk;
    logic rst;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(
        .WIDTH      (W),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 4-bit shift register fed by the serial stream; q3 holds the oldest bit.
    logic [3:0] chain_q;
    always @(posedge clk) begin
        chain_q <= {chain_q[2:0], bus.o_d};
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the bits still to be emitted, front = bit currently on o_d.
    logic model_bits[$];

    typedef struct {
        logic       valid;
        logic [3:0] data;
        logic       exp_d;
        logic       exp_busy;
        logic       exp_last;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[14];

    function automatic logic model_ready();
        return !rst && (model_bits.size() <= 1);
    endfunction

    function automatic logic model_d();
        return (model_bits.size() > 0) ? model_bits[0] : 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, and return 1 time unit after the edge.
    task automatic applyStimulus(input logic valid, input logic [3:0] data);
        logic acc;
        bus.i_valid = valid;
        bus.i_data  = data;
        acc = valid && model_ready();
        @(posedge clk);
        if (rst) begin
            model_bits.delete();
        end else if (acc) begin
            model_bits.delete();
            for (int i = W - 1; i >= 0; i--) model_bits.push_back(data[i]);
        end else if (model_bits.size() > 0) begin
            void'(model_bits.pop_front());
        end
        #1;
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".d"},     bus.o_d,     model_d());
        checkOutput({tag, ".busy"},  bus.o_busy,  model_bits.size() > 0);
        checkOutput({tag, ".last"},  bus.o_last,  model_bits.size() == 1);
        checkOutput({tag, ".ready"}, bus.o_ready, model_ready());
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data  = 4'hF;

        // Single word 1011, a stalled valid, idle, then 1100 and 0011 back to back with a stall.
        vecs[0]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held for 3 cycles with a valid word offered: nothing may be accepted.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst%0d.d", c),     bus.o_d,     1'b0);
            checkOutput($sformatf("rst%0d.busy", c),  bus.o_busy,  1'b0);
            checkOutput($sformatf("rst%0d.last", c),  bus.o_last,  1'b0);
            checkOutput($sformatf("rst%0d.ready", c), bus.o_ready, 1'b0);
        end
        rst = 1'b0;
        model_bits.delete();
        applyStimulus(1'b0, 4'h0);
        checkAgainstModel("post_rst");
        checkOutput("post_rst.ready_abs", bus.o_ready, 1'b1);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d.d", i),     bus.o_d,     vecs[i].exp_d);
            checkOutput($sformatf("vec%0d.busy", i),  bus.o_busy,  vecs[i].exp_busy);
            checkOutput($sformatf("vec%0d.last", i),  bus.o_last,  vecs[i].exp_last);
            checkOutput($sformatf("vec%0d.ready", i), bus.o_ready, vecs[i].exp_ready);
        end

        // Mid-word reset: 1010 aborted after its 2nd bit, then 0110 must serialize from its MSB.
        applyStimulus(1'b1, 4'b1010);
        checkOutput("mid.bit3", bus.o_d, 1'b1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("mid.bit2", bus.o_d, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_bits.delete();
        checkOutput("mid.rst_d",     bus.o_d,     1'b0);
        checkOutput("mid.rst_busy",  bus.o_busy,  1'b0);
        checkOutput("mid.rst_last",  bus.o_last,  1'b0);
        checkOutput("mid.rst_ready", bus.o_ready, 1'b0);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("mid.rst_hold_d", bus.o_d, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 4'b0110);
        checkAgainstModel("mid.w0");
        checkOutput("mid.w0_abs", bus.o_d, 1'b0);
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0000);
            checkAgainstModel($sformatf("mid.w%0d", i));
        end
        checkOutput("mid.idle_ready", bus.o_ready, 1'b1);

        // Chain: continuous 1001 words; the downstream register must show 1001 every 4 cycles.
        for (int k = 1; k <= 13; k++) begin
            applyStimulus(1'b1, 4'b1001);
            checkAgainstModel($sformatf("chain%0d", k));
            if (k >= 5 && (k - 5) % 4 == 0) begin
                checks++;
                if (chain_q !== 4'b1001) begin
                    errors++;
                    $display("[TB] FAIL chain_reg%0d: got %b, expected 1001", k, chain_q);
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 4'h0);
            checkAgainstModel($sformatf("drain%0d", k));
        end

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom));
            checkAgainstModel($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
